// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one 16-bit limb per clock, LSW first, carry chained in a register.
// Latency: accept on edge T, out_valid high after edge T+WORDS; accept-to-accept spacing >= WORDS+2 cycles.
// Backpressure: result/flags held in DONE until out_ready; in_ready low outside IDLE, inputs ignored there.
module mp_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                carry,
  output logic                sign,
  output logic                zero,
  output logic                parity,
  output logic                overflow,
  output logic                busy
);
  localparam int N  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_reg, b_reg;      // b_reg already inverted for subtraction
  logic [N-1:0]  res_acc, res_nxt;  // limbs built up during RUN, published at the end
  logic [KW-1:0] k;
  logic          creg, zero_acc, par_acc;
  logic [15:0]   a_word, b_word;
  logic [16:0]   word_sum;
  logic          last;

  assign a_word   = a_reg[k*16 +: 16];
  assign b_word   = b_reg[k*16 +: 16];
  assign word_sum = {1'b0, a_word} + {1'b0, b_word} + {16'b0, creg};
  assign last     = (k == KW'(WORDS - 1));

  // Merge the current limb into the partial result so the final word can publish it directly
  always_comb begin
    res_nxt = res_acc;
    res_nxt[k*16 +: 16] = word_sum[15:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-limb add with carry chain, and final flag registration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_acc  <= '0;
      k        <= '0;
      creg     <= 1'b0;
      zero_acc <= 1'b0;
      par_acc  <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b ^ {N{sub}};
            creg     <= sub;
            k        <= '0;
            zero_acc <= 1'b1;
            par_acc  <= 1'b0;
          end
        end
        RUN: begin
          res_acc  <= res_nxt;
          creg     <= word_sum[16];
          zero_acc <= zero_acc & (word_sum[15:0] == 16'h0);
          par_acc  <= par_acc ^ (^word_sum[15:0]);
          if (last) begin
            k        <= '0;
            result   <= res_nxt;
            carry    <= word_sum[16];
            sign     <= word_sum[15];
            zero     <= zero_acc & (word_sum[15:0] == 16'h0);
            parity   <= ~(par_acc ^ (^word_sum[15:0]));
            overflow <= (a_word[15] == b_word[15]) & (word_sum[15] != a_word[15]);
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mp_add_sequencer.sv
module tb_mp_add_sequencer;
  logic        clk = 1'b0;
  logic        reset;

  // WORDS=4 instance
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [63:0] a, b, result;
  logic        carry, sign, zero, parity, overflow, busy;

  // WORDS=1 instance
  logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1;
  logic [15:0] a1, b1, result1;
  logic        carry1, sign1, zero1, parity1, overflow1, busy1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mp_add_sequencer #(.WORDS(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .sign(sign), .zero(zero), .parity(parity), .overflow(overflow), .busy(busy)
  );

  mp_add_sequencer #(.WORDS(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .sub(sub1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
    .carry(carry1), .sign(sign1), .zero(zero1), .parity(parity1), .overflow(overflow1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // flags packed as {carry, sign, zero, parity, overflow}
  function automatic logic [4:0] flags4();
    return {carry, sign, zero, parity, overflow};
  endfunction

  // Present one request, check latency; leaves the DUT in DONE with outputs visible
  task automatic start_op(input string tag, input logic [63:0] va, input logic [63:0] vb, input logic vs);
    int cnt;
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1; sub = ~vs;   // inputs need not be held
    chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, 64'(cnt), 64'd4);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovld_drop"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_rdy_back"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; sub = 0; a = 0; b = 0; out_ready = 0;
    in_valid1 = 0; sub1 = 0; a1 = 0; b1 = 0; out_ready1 = 0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {59'b0, flags4()}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // T1 carry chain
    start_op("t1", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    chk("t1_result", result, 64'h0000_0000_0001_0000);
    chk("t1_flags", {59'b0, flags4()}, {59'b0, 5'b00000});
    finish_op("t1");

    // T2 wrap to zero
    start_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    chk("t2_result", result, 64'd0);
    chk("t2_flags", {59'b0, flags4()}, {59'b0, 5'b10110});
    finish_op("t2");

    // T3 subtraction, equal operands then borrow
    start_op("t3a", 64'd5, 64'd5, 1'b1);
    chk("t3a_result", result, 64'd0);
    chk("t3a_flags", {59'b0, flags4()}, {59'b0, 5'b10110});
    finish_op("t3a");
    start_op("t3b", 64'd3, 64'd5, 1'b1);
    chk("t3b_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t3b_flags", {59'b0, flags4()}, {59'b0, 5'b01000});
    finish_op("t3b");

    // T4 signed overflow
    start_op("t4", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    chk("t4_result", result, 64'h8000_0000_0000_0000);
    chk("t4_flags", {59'b0, flags4()}, {59'b0, 5'b01001});

    // T5 backpressure: hold 3 cycles with a competing request present
    a = 64'h1234; b = 64'h1111; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_result", result, 64'h8000_0000_0000_0000);
      chk("t5_hold_flags", {59'b0, flags4()}, {59'b0, 5'b01001});
      chk("t5_hold_in_ready", {63'b0, in_ready}, 64'd0);
      chk("t5_hold_out_valid", {63'b0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    finish_op("t5");
    start_op("t5n", 64'h1234, 64'h1111, 1'b0);
    chk("t5n_result", result, 64'h2345);
    chk("t5n_flags", {59'b0, flags4()}, {59'b0, 5'b00010});
    finish_op("t5n");

    // T6 reset at k=2 aborts the operation
    start_op("t4b", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    finish_op("t4b");
    a = 64'h0000_FFFF_FFFF_FFFF; b = 64'd1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("t6_busy_k2", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_result", result, 64'd0);
    chk("t6_rst_flags", {59'b0, flags4()}, 64'd0);
    chk("t6_rst_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_in_ready", {63'b0, in_ready}, 64'd1);
    begin
      int stray = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b0) stray++;
      end
      chk("t6_no_stray_valid", 64'(stray), 64'd0);
    end

    // T7 WORDS=1 instance
    a1 = 16'hBFFF; b1 = 16'h8000; sub1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("t7_busy", {63'b0, busy1}, 64'd1);
    @(posedge clk); #1;
    chk("t7_out_valid", {63'b0, out_valid1}, 64'd1);
    chk("t7_result", {48'b0, result1}, 64'h3FFF);
    chk("t7_flags", {59'b0, carry1, sign1, zero1, parity1, overflow1}, {59'b0, 5'b10011});
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("t7_in_ready", {63'b0, in_ready1}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
